sseg_rx: RTL and testbench

Receive-side counterpart of the multiplexed seven-segment driver: samples the anode/cathode pins of a time-multiplexed 4-digit display, waits for each digit slot to settle, decodes the segment pattern back to a 4-bit hex value and holds all four digits in registers. It is used as an on-chip loopback checker and display monitor alongside the display driver, and it provides a frame-complete pulse once every digit has been refreshed.

---
 rtl/sseg_pkg.sv | 50 +++++
 rtl/sseg_rx_if.sv | 36 +++
 rtl/sseg2hex.sv | 31 +++
 rtl/sseg_rx.sv | 178 +++++++++++++++++
 tb/tb_sseg_rx.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sseg_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_pkg
//  Purpose  : Shared definitions for the seven-segment encoder/decoder pair.
//             Holds the hex-to-segment table (active-low {g,f,e,d,c,b,a}),
//             the blank pattern, the receiver FSM state type and small
//             anode-decoding helpers.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package sseg_pkg;

    // Active-low segment pattern for each hex digit, index = digit value.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    // All segments off.
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // All anodes off (no digit selected).
    localparam logic [3:0] AN_BLANK = 4'hF;

    typedef enum logic [1:0] {
        ST_SETTLING = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_HOLD     = 2'd2
    } sseg_rx_state_t;

    // True when exactly one anode is driven low.
    function automatic logic an_is_one_hot_low(input logic [3:0] an);
        case (an)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Digit index of a one-hot-low anode; 0 for any other pattern.
    function automatic logic [1:0] an_index(input logic [3:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage : sseg_pkg
`default_nettype wire

// File: rtl/sseg_rx_if.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_rx_if
//  Purpose  : Bundle of the display pins observed by the receiver and the
//             decoded results it reports.
//  Signals  : sseg_an[3:0]     anode pins, active-low
//             sseg_ca[6:0]     cathode pins {g..a}, active-low
//             digit0..digit3   last decoded value per digit
//             digit_valid[3:0] per-digit "holds a good decode"
//             frame_valid      pulse after all four digits refreshed
//             pattern_err      pulse on an undecodable settled slot
//  Modports : master drives the pins and reads results; slave is the receiver.
//  Revision : 1.0  initial release
// ============================================================================
interface sseg_rx_if;
    logic [3:0] sseg_an;
    logic [6:0] sseg_ca;
    logic [3:0] digit0;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit_valid;
    logic       frame_valid;
    logic       pattern_err;

    modport master (
        output sseg_an, sseg_ca,
        input  digit0, digit1, digit2, digit3, digit_valid, frame_valid, pattern_err
    );

    modport slave (
        input  sseg_an, sseg_ca,
        output digit0, digit1, digit2, digit3, digit_valid, frame_valid, pattern_err
    );
endinterface : sseg_rx_if
`default_nettype wire

// File: rtl/sseg2hex.sv
`default_nettype none
// ============================================================================
//  Module   : sseg2hex
//  Purpose  : Combinational inverse of the seven-segment encoder table.
//  Ports    : sseg[6:0]  in   active-low segment pattern {g..a}
//             hex[3:0]   out  decoded digit (0 when invalid)
//             valid      out  pattern matches a table entry
//  Revision : 1.0  initial release
// ============================================================================
module sseg2hex
    import sseg_pkg::*;
(
    input  logic [6:0] sseg,
    output logic [3:0] hex,
    output logic       valid
);

    // Table entries are unique, so at most one iteration matches.
    always_comb begin
        hex   = 4'd0;
        valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (sseg == SEG_HEX[i]) begin
                hex   = 4'(i);
                valid = 1'b1;
            end
        end
    end

endmodule : sseg2hex
`default_nettype wire

// File: rtl/sseg_rx.sv
`default_nettype none
// ============================================================================
//  Module   : sseg_rx
//  Purpose  : Samples the pins of a multiplexed 4-digit seven-segment display,
//             waits for each slot to settle, decodes the cathode pattern and
//             keeps the last value of every digit. Pulses frame_valid once all
//             four digits have been refreshed and pattern_err on a bad slot.
//  Params   : SETTLE_CYCLES  stable cycles required before capture (1..255)
//  Ports    : clk    in   system clock
//             rst_n  in   asynchronous active-low reset
//             bus    slave modport of sseg_rx_if (pins in, results out)
//  Revision : 1.0  initial release
// ============================================================================
module sseg_rx
    import sseg_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    sseg_rx_if.slave    bus
);

    if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 255)) begin : g_bad_settle
        $error("sseg_rx: SETTLE_CYCLES must be in 1..255");
    end

    localparam logic [7:0]  C_SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [10:0] C_SYNC_RESET  = {AN_BLANK, SEG_BLANK};

    // Two-flop synchroniser on {an, ca}; s_q is the only view used downstream.
    logic [10:0]     sync1_q;
    logic [10:0]     s_q;

    sseg_rx_state_t  state_q, state_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [3:0][3:0] digit_q, digit_d;
    logic [3:0]      digit_valid_q, digit_valid_d;
    logic [3:0]      seen_q, seen_d;
    logic            frame_valid_q, frame_valid_d;
    logic            pattern_err_q, pattern_err_d;

    logic [3:0]      w_an;
    logic [6:0]      w_ca;
    logic [3:0]      w_hex;
    logic            w_hex_valid;
    logic            w_change;
    logic            w_capture;
    logic [1:0]      w_idx;
    logic [3:0]      w_seen_next;

    assign w_an = s_q[10:7];
    assign w_ca = s_q[6:0];

    // sync1_q holds the value s_q is about to take, so comparing the two
    // flags a change of s on the very edge that s updates.
    assign w_change = (sync1_q != s_q);
    assign w_idx    = an_index(w_an);

    sseg2hex u_sseg2hex (
        .sseg  (w_ca),
        .hex   (w_hex),
        .valid (w_hex_valid)
    );

    // ------------------------------------------------------------------
    // Settle FSM. The capture is registered on the edge that closes the
    // settle window, so CAPTURE is the cycle in which the new results are
    // first visible; from there the slot is held until s changes.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_capture = 1'b0;

        case (state_q)
            ST_SETTLING: begin
                if (w_change) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == C_SETTLE_LAST) begin
                    state_d   = ST_CAPTURE;
                    cnt_d     = 8'd0;
                    w_capture = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_CAPTURE: begin
                if (w_change) begin
                    state_d = ST_SETTLING;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_change) begin
                    state_d = ST_SETTLING;
                    cnt_d   = 8'd0;
                end
            end
            default: begin
                state_d = ST_SETTLING;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Capture actions and pulse generation.
    // ------------------------------------------------------------------
    always_comb begin
        digit_d       = digit_q;
        digit_valid_d = digit_valid_q;
        seen_d        = seen_q;
        frame_valid_d = 1'b0;
        pattern_err_d = 1'b0;
        w_seen_next   = seen_q;

        if (w_capture) begin
            if (w_an == AN_BLANK) begin
                // Blanked slot between digits: nothing to record.
            end else if (an_is_one_hot_low(w_an)) begin
                if (w_hex_valid) begin
                    digit_d[w_idx]       = w_hex;
                    digit_valid_d[w_idx] = 1'b1;
                    w_seen_next[w_idx]   = 1'b1;
                    if (w_seen_next == 4'hF) begin
                        frame_valid_d = 1'b1;
                        seen_d        = 4'h0;
                    end else begin
                        seen_d        = w_seen_next;
                    end
                end else begin
                    // Keep the stale value but mark it untrusted.
                    digit_valid_d[w_idx] = 1'b0;
                    pattern_err_d        = 1'b1;
                end
            end else begin
                pattern_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q       <= C_SYNC_RESET;
            s_q           <= C_SYNC_RESET;
            state_q       <= ST_SETTLING;
            cnt_q         <= 8'd0;
            digit_q       <= '0;
            digit_valid_q <= 4'h0;
            seen_q        <= 4'h0;
            frame_valid_q <= 1'b0;
            pattern_err_q <= 1'b0;
        end else begin
            sync1_q       <= {bus.sseg_an, bus.sseg_ca};
            s_q           <= sync1_q;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            digit_valid_q <= digit_valid_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            pattern_err_q <= pattern_err_d;
        end
    end

    assign bus.digit0      = digit_q[0];
    assign bus.digit1      = digit_q[1];
    assign bus.digit2      = digit_q[2];
    assign bus.digit3      = digit_q[3];
    assign bus.digit_valid = digit_valid_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.pattern_err = pattern_err_q;

endmodule : sseg_rx
`default_nettype wire

// File: tb/tb_sseg_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sseg_rx
//  Purpose  : Self-checking bench for sseg_rx with SETTLE_CYCLES = 4.
//             A table of display slots with expected digit/valid/pulse
//             results, plus hand-written reset, latency, glitch and
//             reset-mid-dwell sequences.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sseg_rx;

    logic clk;
    logic rst_n;

    sseg_rx_if bus ();

    sseg_rx #(
        .SETTLE_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    // Per-slot observations.
    int         n_err;
    int         n_frame;
    int         err_at;
    int         frame_at;
    logic [3:0] d3_at_frame;
    logic       saw8;

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  ca;
        logic [15:0] digits;   // {digit3, digit2, digit1, digit0}
        logic [3:0]  valid;
        int          err;
        int          frame;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] all_digits();
        return {bus.digit3, bus.digit2, bus.digit1, bus.digit0};
    endfunction

    // Drive one slot for n cycles; pins change just after an edge, so the
    // next rising edge is edge 1 of the slot. Outputs sampled 1 ns after.
    task automatic slot(input logic [3:0] an, input logic [6:0] ca, input int n);
        bus.sseg_an = an;
        bus.sseg_ca = ca;
        n_err    = 0;
        n_frame  = 0;
        err_at   = 0;
        frame_at = 0;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            #1;
            if (bus.pattern_err) begin
                n_err++;
                err_at = k;
            end
            if (bus.frame_valid) begin
                n_frame++;
                frame_at    = k;
                d3_at_frame = bus.digit3;
            end
            if (bus.digit1 == 4'h8) saw8 = 1'b1;
        end
    endtask

    int total_frames;

    initial begin
        checks       = 0;
        errors       = 0;
        saw8         = 1'b0;
        d3_at_frame  = 4'h0;
        total_frames = 0;

        //                an       ca     digits    valid  err frame
        vecs[0]  = '{4'b1110, 7'h79, 16'h0001, 4'b0001, 0, 0};
        vecs[1]  = '{4'b1101, 7'h24, 16'h0021, 4'b0011, 0, 0};
        vecs[2]  = '{4'b1011, 7'h08, 16'h0A21, 4'b0111, 0, 0};
        vecs[3]  = '{4'b0111, 7'h0E, 16'hFA21, 4'b1111, 0, 1};
        vecs[4]  = '{4'b1110, 7'h19, 16'hFA24, 4'b1111, 0, 0};
        vecs[5]  = '{4'b1101, 7'h12, 16'hFA54, 4'b1111, 0, 0};
        vecs[6]  = '{4'b1011, 7'h46, 16'hFC54, 4'b1111, 0, 0};
        vecs[7]  = '{4'b0111, 7'h21, 16'hDC54, 4'b1111, 0, 1};
        vecs[8]  = '{4'b1110, 7'h7E, 16'hDC54, 4'b1110, 1, 0};
        vecs[9]  = '{4'b1100, 7'h40, 16'hDC54, 4'b1110, 1, 0};
        vecs[10] = '{4'b1111, 7'h7F, 16'hDC54, 4'b1110, 0, 0};
        vecs[11] = '{4'b1110, 7'h03, 16'hDC5B, 4'b1111, 0, 0};

        // ---------------- reset behaviour ----------------
        rst_n       = 1'b0;
        bus.sseg_an = 4'($urandom);
        bus.sseg_ca = 7'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk("reset digits",      32'(all_digits()),     32'h0);
        chk("reset digit_valid", 32'(bus.digit_valid),  32'h0);
        chk("reset frame_valid", 32'(bus.frame_valid),  32'h0);
        chk("reset pattern_err", 32'(bus.pattern_err),  32'h0);

        rst_n = 1'b1;
        slot(4'b1111, 7'h7F, 20);
        chk("blank err count",   32'(n_err),           32'h0);
        chk("blank frame count", 32'(n_frame),         32'h0);
        chk("blank digit_valid", 32'(bus.digit_valid), 32'h0);

        // ---------------- single capture latency ----------------
        bus.sseg_an = 4'b1110;
        bus.sseg_ca = 7'h30;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (k == 5) chk("latency edge5 valid", 32'(bus.digit_valid), 32'h0);
            if (k == 6) begin
                chk("latency edge6 digit0", 32'(bus.digit0),      32'h3);
                chk("latency edge6 valid",  32'(bus.digit_valid), 32'h1);
            end
        end
        slot(4'b1110, 7'h30, 100);
        chk("hold err count",   32'(n_err),           32'h0);
        chk("hold frame count", 32'(n_frame),         32'h0);
        chk("hold digits",      32'(all_digits()),    32'h0003);
        chk("hold digit_valid", 32'(bus.digit_valid), 32'h1);

        // ---------------- table-driven slots ----------------
        for (int i = 0; i < 12; i++) begin
            slot(vecs[i].an, vecs[i].ca, 8);
            chk($sformatf("row%0d digits", i),      32'(all_digits()),    32'(vecs[i].digits));
            chk($sformatf("row%0d digit_valid", i), 32'(bus.digit_valid), 32'(vecs[i].valid));
            chk($sformatf("row%0d err count", i),   32'(n_err),           32'(vecs[i].err));
            chk($sformatf("row%0d frame count", i), 32'(n_frame),         32'(vecs[i].frame));
            if (vecs[i].frame != 0) begin
                chk($sformatf("row%0d frame edge", i),   32'(frame_at),    32'd6);
                chk($sformatf("row%0d frame digit3", i), 32'(d3_at_frame), 32'(vecs[i].digits[15:12]));
            end
            if (vecs[i].err != 0) begin
                chk($sformatf("row%0d err edge", i), 32'(err_at), 32'd6);
            end
        end

        // ---------------- glitch rejection ----------------
        saw8 = 1'b0;
        slot(4'b1101, 7'h00, 4);
        chk("glitch short err", 32'(n_err), 32'h0);
        slot(4'b1101, 7'h02, 10);
        chk("glitch digits",   32'(all_digits()), 32'hDC6B);
        chk("glitch never 8",  32'(saw8),         32'h0);
        chk("glitch err",      32'(n_err),        32'h0);

        // ---------------- reset mid-dwell ----------------
        // Leave seen = {3,2,1} so a surviving seen would pulse on digit0.
        slot(4'b1011, 7'h08, 8); total_frames += n_frame;
        slot(4'b0111, 7'h0E, 8); total_frames += n_frame;
        slot(4'b1101, 7'h24, 8); total_frames += n_frame;
        slot(4'b1011, 7'h08, 8); total_frames += n_frame;
        slot(4'b0111, 7'h0E, 8); total_frames += n_frame;
        chk("pre-reset frames", 32'(total_frames), 32'd1);
        chk("pre-reset digits", 32'(all_digits()), 32'hFA2B);

        bus.sseg_an = 4'b1110;
        bus.sseg_ca = 7'h19;
        repeat (4) @(posedge clk);   // settle count now 2
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid-dwell reset digits", 32'(all_digits()),    32'h0);
        chk("mid-dwell reset valid",  32'(bus.digit_valid), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n_frame = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (bus.frame_valid) n_frame++;
            if (k == 5) chk("post-reset edge5 valid", 32'(bus.digit_valid), 32'h0);
            if (k == 6) begin
                chk("post-reset edge6 digit0", 32'(bus.digit0),      32'h4);
                chk("post-reset edge6 valid",  32'(bus.digit_valid), 32'h1);
            end
        end
        chk("post-reset no frame on digit0", 32'(n_frame), 32'h0);

        total_frames = 0;
        slot(4'b1101, 7'h24, 8); total_frames += n_frame;
        slot(4'b1011, 7'h08, 8); total_frames += n_frame;
        chk("post-reset partial frames", 32'(total_frames), 32'h0);
        slot(4'b0111, 7'h0E, 8);
        chk("post-reset full frame",   32'(n_frame),      32'h1);
        chk("post-reset frame edge",   32'(frame_at),     32'd6);
        chk("post-reset final digits", 32'(all_digits()), 32'hFA24);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_sseg_rx
`default_nettype wire
